seg7_score_display: RTL and testbench

//  Board-side output driver for the snake game. Takes the score and master state from the

---
 rtl/snake_pkg.sv | 64 ++++++
 rtl/bcd_converter_8b.sv | 91 +++++++++
 rtl/seg7_score_display.sv | 162 ++++++++++++++++
 tb/tb_seg7_score_display.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : snake_pkg
//  Description : Shared constants for the snake game display path: master
//                state encodings, active-low 7-segment glyphs (gfedcba),
//                the BCD conversion FSM state type and glyph helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package snake_pkg;

    // Master state machine encodings (2'b11 is also treated as END)
    localparam logic [1:0] MSM_IDLE = 2'b00;
    localparam logic [1:0] MSM_PLAY = 2'b01;
    localparam logic [1:0] MSM_END  = 2'b10;

    // Segment glyphs, active-low, bit order gfedcba
    localparam logic [6:0] GLYPH_0     = 7'h40;
    localparam logic [6:0] GLYPH_1     = 7'h79;
    localparam logic [6:0] GLYPH_2     = 7'h24;
    localparam logic [6:0] GLYPH_3     = 7'h30;
    localparam logic [6:0] GLYPH_4     = 7'h19;
    localparam logic [6:0] GLYPH_5     = 7'h12;
    localparam logic [6:0] GLYPH_6     = 7'h02;
    localparam logic [6:0] GLYPH_7     = 7'h78;
    localparam logic [6:0] GLYPH_8     = 7'h00;
    localparam logic [6:0] GLYPH_9     = 7'h10;
    localparam logic [6:0] GLYPH_DASH  = 7'h3F;
    localparam logic [6:0] GLYPH_P     = 7'h0C;
    localparam logic [6:0] GLYPH_E     = 7'h06;
    localparam logic [6:0] GLYPH_BLANK = 7'h7F;

    // Conversion FSM states
    typedef enum logic [1:0] {
        CV_IDLE  = 2'd0,
        CV_SHIFT = 2'd1,
        CV_DONE  = 2'd2
    } cv_state_t;

    // Decimal digit to glyph; out-of-range nibbles show blank
    function automatic logic [6:0] bcd_to_glyph(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = GLYPH_0;
            4'd1:    seg = GLYPH_1;
            4'd2:    seg = GLYPH_2;
            4'd3:    seg = GLYPH_3;
            4'd4:    seg = GLYPH_4;
            4'd5:    seg = GLYPH_5;
            4'd6:    seg = GLYPH_6;
            4'd7:    seg = GLYPH_7;
            4'd8:    seg = GLYPH_8;
            4'd9:    seg = GLYPH_9;
            default: seg = GLYPH_BLANK;
        endcase
        return seg;
    endfunction

    // Both 2'b10 and 2'b11 mean END, so only the upper bit matters
    function automatic logic msm_is_end(input logic [1:0] state);
        return state[1] == MSM_END[1];
    endfunction

endpackage : snake_pkg
`default_nettype wire

// File: rtl/bcd_converter_8b.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_converter_8b
//  Description : Sequential double-dabble, 8-bit binary to 3-digit BCD.
//                One capture cycle, eight shift cycles, one done cycle.
//  Ports       : CLK    in   clock, rising edge
//                RESET  in   synchronous reset, active-high
//                start  in   request a conversion (honoured in CV_IDLE only)
//                bin    in   8-bit value captured on start
//                busy   out  high from capture until the conversion completes
//                done   out  one-cycle pulse; bcd holds the final result
//                bcd    out  {hundreds, tens, units} accumulator
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_converter_8b
    import snake_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic        start,
    input  logic [7:0]  bin,
    output logic        busy,
    output logic        done,
    output logic [11:0] bcd
);

    cv_state_t   r_state_q, w_state_d;
    logic [7:0]  r_bin_q,   w_bin_d;
    logic [11:0] r_acc_q,   w_acc_d;
    logic [2:0]  r_cnt_q,   w_cnt_d;
    logic [11:0] w_adj;

    always_comb begin
        w_state_d = r_state_q;
        w_bin_d   = r_bin_q;
        w_acc_d   = r_acc_q;
        w_cnt_d   = r_cnt_q;

        // Add-3 correction on every nibble that would overflow past 9 after the shift
        w_adj = r_acc_q;
        for (int i = 0; i < 3; i++) begin
            if (r_acc_q[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_acc_q[4*i +: 4] + 4'd3;
            end
        end

        case (r_state_q)
            CV_IDLE: begin
                if (start) begin
                    w_bin_d   = bin;
                    w_acc_d   = '0;
                    w_cnt_d   = '0;
                    w_state_d = CV_SHIFT;
                end
            end
            CV_SHIFT: begin
                {w_acc_d, w_bin_d} = {w_adj[10:0], r_bin_q, 1'b0};
                w_cnt_d            = r_cnt_q + 3'd1;
                if (r_cnt_q == 3'd7) begin
                    w_state_d = CV_DONE;
                end
            end
            CV_DONE: begin
                w_state_d = CV_IDLE;
            end
            default: begin
                w_state_d = CV_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state_q <= CV_IDLE;
            r_bin_q   <= '0;
            r_acc_q   <= '0;
            r_cnt_q   <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_bin_q   <= w_bin_d;
            r_acc_q   <= w_acc_d;
            r_cnt_q   <= w_cnt_d;
        end
    end

    assign busy = (r_state_q != CV_IDLE);
    assign done = (r_state_q == CV_DONE);
    assign bcd  = r_acc_q;

endmodule : bcd_converter_8b
`default_nettype wire

// File: rtl/seg7_score_display.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_score_display
//  Description : Drives the 4-digit multiplexed 7-segment display of the
//                snake game: score (BCD, leading-zero blanked) on digits 0..2,
//                a state glyph on digit 3, and an end-of-game blink.
//  Ports       : CLK         in   clock, rising edge
//                RESET       in   synchronous reset, active-high
//                SCORE       in   8-bit game score
//                MSM_State   in   master state (00 IDLE, 01 PLAY, 1x END)
//                SEG_SELECT  out  digit anodes, active-low, bit 0 rightmost
//                HEX_OUT     out  segments, active-low, [7]=dp, [6:0]=gfedcba
//                BUSY        out  BCD conversion in progress
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_score_display
    import snake_pkg::*;
#(
    parameter int CLK_HZ   = 100_000_000,
    parameter int SCAN_HZ  = 1_000,
    parameter int BLINK_HZ = 2
)
(
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] SCORE,
    input  logic [1:0] MSM_State,
    output logic [3:0] SEG_SELECT,
    output logic [7:0] HEX_OUT,
    output logic       BUSY
);

    localparam int SCAN_TERM  = CLK_HZ / SCAN_HZ - 1;
    localparam int BLINK_TERM = CLK_HZ / (2 * BLINK_HZ) - 1;
    // Sized to hold the terminal count itself (a power-of-two terminal needs the extra bit)
    localparam int SCAN_W     = (SCAN_TERM  > 0) ? $clog2(SCAN_TERM  + 1) : 1;
    localparam int BLINK_W    = (BLINK_TERM > 0) ? $clog2(BLINK_TERM + 1) : 1;

    // Change detection and converter hookup
    logic [7:0]   r_last_conv_q, w_last_conv_d;
    logic [11:0]  r_disp_q,      w_disp_d;
    logic         w_start;
    logic         w_conv_busy;
    logic         w_conv_done;
    logic [11:0]  w_conv_bcd;

    // Scan and blink
    logic [SCAN_W-1:0]  r_presc_q,     w_presc_d;
    logic [1:0]         r_idx_q,       w_idx_d;
    logic [BLINK_W-1:0] r_blink_cnt_q, w_blink_cnt_d;
    logic               r_phase_on_q,  w_phase_on_d;
    logic [3:0]         r_seg_sel_q,   w_seg_sel_d;
    logic [7:0]         r_hex_q,       w_hex_d;

    logic [3:0] w_units, w_tens, w_hund;
    logic [6:0] w_seg;
    logic       w_is_end;
    logic       w_blank;

    // A change seen while busy stays pending: last_conv still differs once idle
    assign w_start = (SCORE != r_last_conv_q) && !w_conv_busy;

    bcd_converter_8b u_bcd (
        .CLK   (CLK),
        .RESET (RESET),
        .start (w_start),
        .bin   (SCORE),
        .busy  (w_conv_busy),
        .done  (w_conv_done),
        .bcd   (w_conv_bcd)
    );

    assign w_units  = r_disp_q[3:0];
    assign w_tens   = r_disp_q[7:4];
    assign w_hund   = r_disp_q[11:8];
    assign w_is_end = msm_is_end(MSM_State);

    always_comb begin
        w_last_conv_d = r_last_conv_q;
        w_disp_d      = r_disp_q;
        w_presc_d     = r_presc_q + SCAN_W'(1);
        w_idx_d       = r_idx_q;
        w_blink_cnt_d = '0;
        w_phase_on_d  = 1'b1;
        w_seg         = GLYPH_BLANK;

        if (w_start) begin
            w_last_conv_d = SCORE;
        end
        // Only a completed conversion reaches the display register
        if (w_conv_done) begin
            w_disp_d = w_conv_bcd;
        end

        if (r_presc_q == SCAN_W'(SCAN_TERM)) begin
            w_presc_d = '0;
            w_idx_d   = r_idx_q + 2'd1;
        end

        // Outside END the blink is held at ON with a cleared counter,
        // so every entry to END starts a fresh ON half-period.
        if (w_is_end) begin
            w_phase_on_d  = r_phase_on_q;
            w_blink_cnt_d = r_blink_cnt_q + BLINK_W'(1);
            if (r_blink_cnt_q == BLINK_W'(BLINK_TERM)) begin
                w_blink_cnt_d = '0;
                w_phase_on_d  = !r_phase_on_q;
            end
        end

        case (r_idx_q)
            2'd0: w_seg = bcd_to_glyph(w_units);
            2'd1: w_seg = (w_hund == 4'd0 && w_tens == 4'd0) ? GLYPH_BLANK : bcd_to_glyph(w_tens);
            2'd2: w_seg = (w_hund == 4'd0) ? GLYPH_BLANK : bcd_to_glyph(w_hund);
            default: begin
                if (w_is_end) begin
                    w_seg = GLYPH_E;
                end else if (MSM_State == MSM_PLAY) begin
                    w_seg = GLYPH_P;
                end else begin
                    w_seg = GLYPH_DASH;
                end
            end
        endcase
        if (MSM_State == MSM_IDLE) begin
            w_seg = GLYPH_DASH;
        end

        // State is used directly so leaving END un-blanks on the very next edge
        w_blank     = w_is_end && !r_phase_on_q;
        w_seg_sel_d = w_blank ? 4'hF  : ~(4'b0001 << r_idx_q);
        w_hex_d     = w_blank ? 8'hFF : {1'b1, w_seg};
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_last_conv_q <= '0;
            r_disp_q      <= '0;
            r_presc_q     <= '0;
            r_idx_q       <= '0;
            r_blink_cnt_q <= '0;
            r_phase_on_q  <= 1'b1;
            r_seg_sel_q   <= 4'hF;
            r_hex_q       <= 8'hFF;
        end else begin
            r_last_conv_q <= w_last_conv_d;
            r_disp_q      <= w_disp_d;
            r_presc_q     <= w_presc_d;
            r_idx_q       <= w_idx_d;
            r_blink_cnt_q <= w_blink_cnt_d;
            r_phase_on_q  <= w_phase_on_d;
            r_seg_sel_q   <= w_seg_sel_d;
            r_hex_q       <= w_hex_d;
        end
    end

    assign SEG_SELECT = r_seg_sel_q;
    assign HEX_OUT    = r_hex_q;
    assign BUSY       = w_conv_busy;

endmodule : seg7_score_display
`default_nettype wire

// File: tb/tb_seg7_score_display.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg7_score_display
//  Description : Self-checking bench for seg7_score_display with short
//                timing parameters (10-cycle digit dwell, 50-cycle blink).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_score_display;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic [7:0] SCORE = 8'd0;
    logic [1:0] MSM_State = 2'b01;
    logic [3:0] SEG_SELECT;
    logic [7:0] HEX_OUT;
    logic       BUSY;

    int n_vec = 0;
    int n_err = 0;
    logic [11:0] sb[$];

    seg7_score_display #(
        .CLK_HZ   (1000),
        .SCAN_HZ  (100),
        .BLINK_HZ (10)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .SCORE      (SCORE),
        .MSM_State  (MSM_State),
        .SEG_SELECT (SEG_SELECT),
        .HEX_OUT    (HEX_OUT),
        .BUSY       (BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] glyph(input int v);
        case (v)
            0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
            4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
            8: return 7'h00;  9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    // Reference digit content from plain decimal arithmetic
    function automatic logic [7:0] exp_hex(input int score, input logic [1:0] st, input int d);
        logic [6:0] g;
        if (st == 2'b00)      g = 7'h3F;
        else if (d == 3)      g = (st == 2'b01) ? 7'h0C : 7'h06;
        else if (d == 0)      g = glyph(score % 10);
        else if (d == 1)      g = (score < 10)  ? 7'h7F : glyph((score / 10) % 10);
        else                  g = (score < 100) ? 7'h7F : glyph(score / 100);
        return {1'b1, g};
    endfunction

    function automatic logic [3:0] anode(input int d);
        logic [3:0] one = 4'b0001;
        return ~(one << d);
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Queue the expected frame, lock onto the start of a digit-0 window,
    // then compare each digit's anode, segments and dwell time.
    task automatic check_frame(input string tag);
        logic [3:0]  prev;
        logic [11:0] e;
        bit          found = 0;
        int          len;
        for (int d = 0; d < 4; d++) sb.push_back({anode(d), exp_hex(SCORE, MSM_State, d)});
        prev = SEG_SELECT;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge CLK);
            if (SEG_SELECT == 4'b1110 && prev != 4'b1110) found = 1;
            prev = SEG_SELECT;
        end
        chk({tag, ".sync"}, found, 1);
        for (int d = 0; d < 4; d++) begin
            e = sb.pop_front();
            chk($sformatf("%s.sel%0d", tag, d), SEG_SELECT, e[11:8]);
            chk($sformatf("%s.hex%0d", tag, d), HEX_OUT, e[7:0]);
            len = 0;
            while (SEG_SELECT == e[11:8] && len < 20) begin
                len++;
                @(negedge CLK);
            end
            chk($sformatf("%s.dwell%0d", tag, d), len, 10);
        end
    endtask

    initial begin
        int hi;
        int bad;
        bit exp_blank;

        // Power-on reset
        RESET = 1'b1; MSM_State = 2'b01; SCORE = 8'd0;
        cycles(3);
        chk("por.sel", SEG_SELECT, 4'hF);
        chk("por.hex", HEX_OUT, 8'hFF);
        chk("por.busy", BUSY, 0);
        RESET = 1'b0;
        cycles(15);

        // Reset mid-scan with SCORE=77
        SCORE = 8'd77; RESET = 1'b1;
        @(negedge CLK);
        chk("rst.sel", SEG_SELECT, 4'hF);
        chk("rst.hex", HEX_OUT, 8'hFF);
        chk("rst.busy", BUSY, 0);
        cycles(2);
        RESET = 1'b0;
        @(negedge CLK);
        chk("rst.conv_start", BUSY, 1);
        cycles(12);
        check_frame("s77");

        // Score zero: only the units digit lit
        SCORE = 8'd0;
        cycles(12);
        check_frame("s0");

        // 0 -> 255: busy duration and result
        SCORE = 8'd255;
        hi = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge CLK);
            if (BUSY) hi++;
        end
        chk("s255.busy_len", hi, 9);
        check_frame("s255");

        SCORE = 8'd100;
        cycles(12);
        check_frame("s100");

        // 37 then 200 one cycle later: reconversion within 20 cycles
        SCORE = 8'd37;
        @(negedge CLK);
        SCORE = 8'd200;
        cycles(18);
        chk("s200.busy19", BUSY, 1);
        @(negedge CLK);
        chk("s200.busy20", BUSY, 0);
        check_frame("s200");
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge CLK);
            if (SEG_SELECT == 4'b1110 && HEX_OUT == 8'hF8) bad++;
        end
        chk("s200.no37", bad, 0);

        // END blink: 50 on / 50 off, then back to PLAY mid-OFF
        MSM_State = 2'b10; SCORE = 8'd42;
        for (int i = 0; i < 170; i++) begin
            @(negedge CLK);
            exp_blank = (i >= 50 && i < 100) || (i >= 150);
            chk($sformatf("end.blank%0d", i), SEG_SELECT == 4'hF, exp_blank);
            if (exp_blank)
                chk($sformatf("end.hexoff%0d", i), HEX_OUT, 8'hFF);
            else if (SEG_SELECT == 4'b0111)
                chk($sformatf("end.glyph%0d", i), HEX_OUT, 8'h86);
        end
        MSM_State = 2'b01;
        @(negedge CLK);
        chk("end.resume", SEG_SELECT != 4'hF, 1);

        // IDLE: dashes everywhere, conversion still runs
        MSM_State = 2'b00; SCORE = 8'd99;
        @(negedge CLK);
        chk("idle.busy", BUSY, 1);
        cycles(12);
        check_frame("idle");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_seg7_score_display
`default_nettype wire
